// File: rtl/imem_boot_if.sv
// Loader, fetch and instruction-RAM signals shared by imem_boot_ctrl and its surroundings.
// master = controller side, slave = loader/fetch/RAM side.
interface imem_boot_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 6
);
    logic             ld_start;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_ready;
    logic [31:0]      pc;
    logic [WIDTH-1:0] instr;
    logic             fetch_fault;
    logic             cpu_rst;
    logic             load_done;
    logic             err_full;
    logic [AW:0]      word_count;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport master (
        input  ld_start, ld_valid, ld_data, ld_last, pc, mem_rd,
        output ld_ready, instr, fetch_fault, cpu_rst, load_done, err_full,
               word_count, mem_we, mem_addr, mem_wd
    );

    modport slave (
        output ld_start, ld_valid, ld_data, ld_last, pc, mem_rd,
        input  ld_ready, instr, fetch_fault, cpu_rst, load_done, err_full,
               word_count, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot/arbiter: loads a program word per handshake, zero-fills the rest, then serves fetch.
// Fetch is combinational (zero latency); loader is accepted every LOAD cycle, never in CLEAR/RUN.
module imem_boot_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    imem_boot_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   WC_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]       state_q, state_d;
    logic [AW:0]      word_count_q, word_count_d;
    logic [AW-1:0]    fill_q, fill_d;
    logic             err_full_q, err_full_d;

    logic             ld_ready, cpu_rst, load_done, fetch_fault, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wd, instr;
    logic             pc_fault;

    assign pc_fault = (bus.pc[1:0] != 2'b00) || (bus.pc[31:AW+2] != '0);

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        fill_d       = fill_q;
        err_full_d   = err_full_q;
        ld_ready     = 1'b0;
        cpu_rst      = 1'b1;
        load_done    = 1'b0;
        fetch_fault  = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wd       = '0;
        instr        = '0;

        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                ld_ready = 1'b1;
                mem_addr = word_count_q[AW-1:0];
                if (bus.ld_valid) begin
                    mem_we       = 1'b1;
                    mem_wd       = bus.ld_data;
                    word_count_d = word_count_q + WC_ONE;
                    // The DEPTH-th word leaves nothing to clear, with or without ld_last.
                    if (word_count_q == LAST_IDX) begin
                        state_d    = S_RUN;
                        err_full_d = err_full_q | ~bus.ld_last;
                    end else if (bus.ld_last) begin
                        state_d = S_CLEAR;
                        fill_d  = word_count_q[AW-1:0] + PTR_ONE;
                    end
                end
            end
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = fill_q;
                fill_d   = fill_q + PTR_ONE;
                if (fill_q == {AW{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cpu_rst     = 1'b0;
                load_done   = 1'b1;
                mem_addr    = bus.pc[AW+1:2];
                fetch_fault = pc_fault;
                instr       = pc_fault ? '0 : bus.mem_rd;
                if (bus.ld_start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
                    err_full_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            fill_q       <= '0;
            err_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            fill_q       <= fill_d;
            err_full_q   <= err_full_d;
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.cpu_rst     = cpu_rst;
    assign bus.load_done   = load_done;
    assign bus.fetch_fault = fetch_fault;
    assign bus.instr       = instr;
    assign bus.err_full    = err_full_q;
    assign bus.word_count  = word_count_q;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wd      = mem_wd;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected RAM writes and signal probes are queued by stimulus
// and retired by a monitor on the falling edge.
module tb_imem_boot_ctrl;
    localparam int K_CPU_RST = 0;
    localparam int K_LD_RDY  = 1;
    localparam int K_DONE    = 2;
    localparam int K_WC      = 3;
    localparam int K_ERR     = 4;
    localparam int K_INSTR   = 5;
    localparam int K_FAULT   = 6;
    localparam int K_ADDR    = 7;
    localparam int K_WE      = 8;
    localparam int K_WD      = 9;
    localparam int K_WQ      = 10;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } probe_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem [64];
    probe_t      probe_q[$];
    wr_t         wr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wc = 0;

    imem_boot_if #(.WIDTH(32), .AW(6)) bus();

    imem_boot_ctrl #(.DEPTH(64), .AW(6), .WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_addr];

    function automatic string kname(input int k);
        case (k)
            K_CPU_RST: return "cpu_rst";
            K_LD_RDY:  return "ld_ready";
            K_DONE:    return "load_done";
            K_WC:      return "word_count";
            K_ERR:     return "err_full";
            K_INSTR:   return "instr";
            K_FAULT:   return "fetch_fault";
            K_ADDR:    return "mem_addr";
            K_WE:      return "mem_we";
            K_WD:      return "mem_wd";
            default:   return "pending_writes";
        endcase
    endfunction

    function automatic logic [31:0] sig(input int k);
        case (k)
            K_CPU_RST: return {31'b0, bus.cpu_rst};
            K_LD_RDY:  return {31'b0, bus.ld_ready};
            K_DONE:    return {31'b0, bus.load_done};
            K_WC:      return {25'b0, bus.word_count};
            K_ERR:     return {31'b0, bus.err_full};
            K_INSTR:   return bus.instr;
            K_FAULT:   return {31'b0, bus.fetch_fault};
            K_ADDR:    return {26'b0, bus.mem_addr};
            K_WE:      return {31'b0, bus.mem_we};
            K_WD:      return bus.mem_wd;
            default:   return 32'(wr_q.size());
        endcase
    endfunction

    // Monitor: retires one expected write per mem_we cycle, then every queued probe.
    always @(negedge clk) begin
        probe_t      p;
        wr_t         w;
        logic [31:0] act;
        if (bus.mem_we === 1'b1) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_bad++;
                $display("FAIL write_unexpected: got addr %0d data %h, required no write", bus.mem_addr, bus.mem_wd);
            end else begin
                w = wr_q.pop_front();
                if (bus.mem_addr !== w.addr || bus.mem_wd !== w.data) begin
                    n_bad++;
                    $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                             bus.mem_addr, bus.mem_wd, w.addr, w.data);
                end
            end
        end
        while (probe_q.size() > 0) begin
            p   = probe_q.pop_front();
            act = sig(p.kind);
            n_cmp++;
            if (act !== p.exp) begin
                n_bad++;
                $display("FAIL %s @%0t: got %h, required %h", kname(p.kind), $time, act, p.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int k, input logic [31:0] e);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        probe_q.push_back(p);
    endtask

    task automatic exp_write(input int a, input logic [31:0] d);
        wr_t w;
        w.addr = 6'(a);
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        exp_write(wc, d);
        wc++;
        step();
    endtask

    // Caller is in the first CLEAR cycle; returns in the first RUN cycle.
    task automatic clear_phase(input int n);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        for (int a = 64 - n; a < 64; a++) exp_write(a, 32'h0);
        for (int i = 0; i < n; i++) begin
            chk(K_CPU_RST, 1);
            chk(K_LD_RDY, 0);
            chk(K_WE, 1);
            step();
        end
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] ei, input logic ef);
        bus.pc = p;
        chk(K_INSTR, ei);
        chk(K_FAULT, {31'b0, ef});
        step();
    endtask

    task automatic reload();
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        wc = 0;
        chk(K_CPU_RST, 1);
        chk(K_LD_RDY, 1);
        chk(K_WC, 0);
        chk(K_ERR, 0);
        chk(K_DONE, 0);
        chk(K_INSTR, 0);
        chk(K_FAULT, 0);
    endtask

    task automatic run_state(input int exp_wc, input logic exp_err);
        chk(K_CPU_RST, 0);
        chk(K_DONE, 1);
        chk(K_LD_RDY, 0);
        chk(K_WE, 0);
        chk(K_WC, 32'(exp_wc));
        chk(K_ERR, {31'b0, exp_err});
    endtask

    initial begin
        logic [31:0] prog [3];
        prog[0] = 32'h20020005;
        prog[1] = 32'h2003000C;
        prog[2] = 32'hAC020054;

        reset_n      = 1'b0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.pc       = 32'h8;
        #1;
        chk(K_CPU_RST, 1); chk(K_LD_RDY, 0); chk(K_WE, 0); chk(K_DONE, 0);
        chk(K_FAULT, 0); chk(K_INSTR, 0); chk(K_ADDR, 0); chk(K_WD, 0);
        chk(K_WC, 0); chk(K_ERR, 0);
        step();
        step();
        reset_n = 1'b1;
        chk(K_LD_RDY, 0);
        chk(K_CPU_RST, 1);
        step();
        chk(K_LD_RDY, 1);
        chk(K_CPU_RST, 1);
        chk(K_WC, 0);

        // Three-word program, 61 clear cycles, then release.
        for (int i = 0; i < 3; i++) send(prog[i], i == 2);
        chk(K_WC, 3);
        clear_phase(61);
        run_state(3, 0);
        fetch(32'h8, 32'hAC020054, 0);
        fetch(32'h0, 32'h20020005, 0);
        fetch(32'hC, 32'h0, 0);
        bus.pc = 32'h6;
        chk(K_ADDR, 1);
        fetch(32'h6, 32'h0, 1);
        fetch(32'h100, 32'h0, 1);

        // Full 64-word load with ld_last, valid toggled at the start.
        bus.pc = 32'h6;
        reload();
        send(32'hA5000000, 0);
        bus.ld_valid = 1'b0;
        chk(K_WE, 0); chk(K_WC, 1);
        step();
        send(32'hA5000001, 0);
        bus.ld_valid = 1'b0;
        chk(K_WE, 0); chk(K_WC, 2);
        step();
        for (int i = 2; i < 64; i++) send(32'hA5000000 | 32'(i), i == 63);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        run_state(64, 0);
        fetch(32'hFC, 32'hA500003F, 0);
        fetch(32'h4, 32'hA5000001, 0);
        fetch(32'h100, 32'h0, 1);

        // Full load without ld_last: overflow flag, loader refused afterwards.
        reload();
        for (int i = 0; i < 64; i++) send(32'h5A000000 | 32'(i), 0);
        bus.ld_data = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            run_state(64, 1);
            step();
        end
        bus.ld_valid = 1'b0;
        fetch(32'h10, 32'h5A000004, 0);

        // One-word program: 63 clear writes.
        reload();
        send(32'hDEADBEEF, 1);
        clear_phase(63);
        run_state(1, 0);
        fetch(32'h0, 32'hDEADBEEF, 0);
        fetch(32'hFC, 32'h0, 0);

        // Reset in the middle of a load.
        reload();
        for (int i = 0; i < 10; i++) send(32'hC0000000 | 32'(i), 0);
        reset_n = 1'b0;
        chk(K_CPU_RST, 1); chk(K_LD_RDY, 0); chk(K_WE, 0); chk(K_WC, 0);
        chk(K_ADDR, 0); chk(K_WD, 0); chk(K_DONE, 0);
        step();
        reset_n      = 1'b1;
        bus.ld_valid = 1'b0;
        wc           = 0;
        chk(K_LD_RDY, 0);
        chk(K_CPU_RST, 1);
        step();
        chk(K_LD_RDY, 1);
        chk(K_WC, 0);
        send(32'h12345678, 1);
        clear_phase(63);
        run_state(1, 0);
        fetch(32'h0, 32'h12345678, 0);

        chk(K_WQ, 0);
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Sequencing and arbitration controller for the processor's 64-word instruction memory. After reset it owns the memory port and loads a program, one word per handshake, from a streaming loader. It then zero-fills the unused words and releases the processor. From then on it steers the memory address from the fetch-stage PC, until a reload is requested. It sits between the loader interface, the fetch stage (PC in, instruction out) and a single-port, write-capable instruction RAM with combinational read.

## Interface
- DEPTH, 64, instruction words in memory (power of two)
- AW, 6, memory word-address width, log2(DEPTH)
- WIDTH, 32, instruction word width
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- ld_start  in  1  request a reload; honoured only in RUN
- ld_valid  in  1  loader word valid
- ld_data  in  WIDTH  loader word
- ld_last  in  1  marks the final word of the program; qualified by ld_valid
- ld_ready  out  1  controller accepts a loader word this cycle
- pc  in  32  fetch-stage byte address
- instr  out  WIDTH  fetched instruction
- fetch_fault  out  1  pc misaligned or out of range (RUN only)
- cpu_rst  out  1  holds the processor in reset while high
- load_done  out  1  high only in RUN
- err_full  out  1  sticky: DEPTH words received without ld_last
- word_count  out  AW+1  words written by the most recent load
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wd  out  WIDTH  RAM write data
- mem_rd  in  WIDTH  RAM read data (combinational)

## Operation
- States: IDLE, LOAD, CLEAR, RUN; state register reset to IDLE.
- IDLE: all outputs 0 except cpu_rst=1. Unconditional transition to LOAD.
- LOAD:
  - ld_ready=1, cpu_rst=1.
  - Handshake (ld_valid & ld_ready) writes in the same cycle: mem_we=1, mem_addr=word_count[AW-1:0], mem_wd=ld_data. word_count increments on the following edge.
  - Handshake with ld_last: exit to CLEAR. If that was word DEPTH, exit directly to RUN instead.
  - Handshake on word DEPTH without ld_last: set err_full, go to RUN; the loader's extra words are never accepted.
  - No handshake: mem_we=0, hold.
- CLEAR:
  - Internal fill pointer starts at word_count and writes 0x00000000 once per cycle (mem_we=1) up to DEPTH-1.
  - Transition to RUN on the edge after the write to DEPTH-1.
  - word_count does not change.
- RUN:
  - cpu_rst=0, load_done=1, mem_we=0, ld_ready=0.
  - mem_addr=pc[AW+1:2], instr=mem_rd.
  - fetch_fault=1 when pc[1:0]!=0 or pc[31:AW+2]!=0; instr is then forced to 0 while mem_addr remains pc[AW+1:2].
- Reload: ld_start in RUN goes to LOAD on the next edge. word_count and err_full clear on that edge, and cpu_rst=1 from that cycle.
- ld_start outside RUN is ignored.
- ld_start and the reset edge coincide: reset wins.
- Outside RUN, instr=0 and fetch_fault=0.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, word_count=0, fill pointer=0, err_full=0.
  - Outputs during reset: cpu_rst=1; ld_ready, mem_we, load_done, fetch_fault, instr, mem_addr and mem_wd all 0.
- Reset asserted mid-LOAD or mid-CLEAR: immediate return to IDLE. The partial program is abandoned and memory contents are unspecified.
- First possible ld_ready: one cycle after the first clock edge following reset release (the IDLE cycle).
- Load throughput: one word per cycle with ld_valid held high.
- Clear throughput: DEPTH - N cycles for an N-word program.
- Release latency: load of N<DEPTH words ending at edge t gives CLEAR for cycles t..t+DEPTH-N-1, with RUN and cpu_rst=0 from edge t+DEPTH-N.
- Full load: RUN from the edge after the DEPTH-th handshake.
- RUN fetch is combinational from pc to instr: zero added latency, so single-cycle fetch timing is unchanged.
- Outputs decoded from state: ld_ready, cpu_rst, load_done.
- Registered: word_count, err_full, fill pointer, state.

## Test plan
- Reset then stream 3 words (0x20020005, 0x2003000C, 0xAC020054) with ld_last on the third -> written to addresses 0,1,2; addresses 3..63 written 0 over 61 CLEAR cycles; word_count=3; cpu_rst falls on the next edge; pc=0x8 gives instr=0xAC020054.
- Stream 64 words with ld_last on word 64 -> no CLEAR, RUN on the next edge, err_full=0, word_count=64. Repeat without ld_last -> err_full=1, ld_ready=0 thereafter.
- ld_valid toggled 1,0,1,0 -> writes only on the valid cycles; addresses stay contiguous.
- In RUN, pc=0x6 -> fetch_fault=1, instr=0. pc=0x100 -> fetch_fault=1. pc=0xFC -> instr=mem[63], fault=0.
- ld_start in RUN -> LOAD next cycle with cpu_rst=1, word_count=0, err_full cleared. Load 1 word -> 63 CLEAR writes, then RUN.
- reset_n pulsed low mid-LOAD after 10 words -> outputs take reset values immediately; IDLE then LOAD; word_count restarts at 0.
